comb_vector_sequencer: RTL and testbench
========================================

Name: comb_vector_sequencer

Overview:
Self-checking stimulus controller for the team's small combinational gate blocks, such as the 2-input A/B -> C unit. On a start request it walks the block's inputs through every combination in ascending order and holds each one for a fixed number of clocks. At the end of each hold it samples the block's output and compares it against a parameterised truth table. It reports an error count, the first failing vector and a pass flag, so the gate bench becomes a synthesizable, clocked checker.

Parameters:
N_IN, 2, number of inputs on the block under control; the sequencer visits 2^N_IN vectors.
HOLD, 4, clocks each vector is held (>=1); the output is sampled on the last hold cycle.
TRUTH, 4'b1000, expected output per vector (width 2^N_IN); bit i is the expected C when the vector equals i. The default is AND.

Ports:
CLK  in  1  sole clock, rising edge
RST  in  1  synchronous, active-high reset
START  in  1  run request, sampled only when idle
ABORT  in  1  cancel the current run
VEC  out  N_IN  drive to the block inputs; VEC[N_IN-1] drives A and VEC[0] drives B
VEC_VALID  out  1  high while VEC is being applied
C_IN  in  1  output of the block under control
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse when a run completes normally
PASS  out  1  high after a completed run with zero mismatches
ERR_COUNT  out  N_IN+1  mismatches in the current or last run
FIRST_FAIL  out  N_IN  vector index of the first mismatch
FAIL_SEEN  out  1  FIRST_FAIL is valid

Behaviour:
- The interface uses one clock, CLK. Reset is RST, synchronous and active-high.
- The state machine has two states, IDLE and DRIVE. Internal registers:
  - hold counter, ceil(log2(HOLD)) bits, minimum 1 bit
  - VEC register
- Reset values (next edge with RST=1, from any state): IDLE, VEC=0, VEC_VALID=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FIRST_FAIL=0, FAIL_SEEN=0, hold counter=0.
- IDLE with START=1 and ABORT=0, at the next edge:
  - state goes to DRIVE; VEC=0, VEC_VALID=1, BUSY=1, hold counter=0
  - PASS, ERR_COUNT, FIRST_FAIL and FAIL_SEEN are cleared
  - latency from START to the first VEC_VALID is 1 cycle
- DRIVE:
  - VEC stays stable and the hold counter increments each cycle.
  - When hold counter == HOLD-1, C_IN is sampled at that edge and compared with TRUTH[VEC].
  - On a mismatch: ERR_COUNT += 1. If FAIL_SEEN=0, FIRST_FAIL=VEC and FAIL_SEEN=1. ERR_COUNT cannot wrap because its maximum is 2^N_IN.
  - If VEC < 2^N_IN-1: VEC increments and the hold counter returns to 0.
  - If VEC == 2^N_IN-1: return to IDLE with VEC=0, VEC_VALID=0, BUSY=0, DONE=1 for exactly one cycle, and PASS = (final ERR_COUNT == 0). The final count includes the mismatch found on this last sample.
- Each vector is applied for exactly HOLD cycles, so VEC_VALID is high for HOLD*2^N_IN consecutive cycles. DONE rises on the cycle after the last sample edge.
- C_IN is assumed combinational from VEC. The sequencer adds no synchronizer.
- START while BUSY is ignored. START held high continuously starts a new run each time the sequencer is IDLE.
- START during the DONE cycle (state is IDLE) is accepted and begins a back-to-back run on the next edge. Results are cleared at that edge; DONE still pulses for its one cycle.
- ABORT while BUSY, at the next edge:
  - state goes to IDLE; VEC=0, VEC_VALID=0, BUSY=0, PASS=0, and no DONE
  - ERR_COUNT, FIRST_FAIL and FAIL_SEEN keep their partial values
  - if ABORT lands on the final sample edge, ABORT wins: that sample is not counted and DONE is not pulsed
- ABORT and START together while IDLE: ABORT wins and no run starts.
- RST mid-run overrides START and ABORT and applies all reset values at the next edge.

Test Plan:
All scenarios use defaults (N_IN=2, HOLD=4, TRUTH=4'b1000).
1. Reset: RST=1 for 2 cycles with START=1 -> every output is 0 and BUSY stays 0.
2. C_IN = A&B model, START pulse at cycle 0 -> VEC is 0,1,2,3 for 4 cycles each (cycles 1-16), DONE at cycle 17, PASS=1, ERR_COUNT=0, FAIL_SEEN=0.
3. C_IN = A|B -> mismatches at vectors 1 and 2. Result: ERR_COUNT=2, FIRST_FAIL=1, FAIL_SEEN=1, PASS=0, DONE pulses once. Then C_IN = ~(A&B) -> ERR_COUNT=4, FIRST_FAIL=0, with no wrap.
4. C_IN stuck at 0 -> ERR_COUNT=1 and FIRST_FAIL=3, both set at the final sample; PASS=0.
5. ABORT at cycle 10 (vector 2) -> at cycle 11 BUSY=0, VEC_VALID=0, PASS=0, and no DONE in the following 20 cycles. A new START then runs cleanly to PASS=1.
6. START pulses at cycle 5 (ignored); START in the DONE cycle -> a second run starts with no gap and counts are cleared. RST at cycle 8 of that run -> reset values on the next cycle.

Source files
------------

// File: rtl/comb_vector_sequencer.sv
// Clocked stimulus/checker for small combinational blocks: walks every input
// vector in ascending order, holds each for HOLD clocks and checks the output.
module comb_vector_sequencer #(
   parameter int                  N_IN  = 2,
   parameter int                  HOLD  = 4,
   parameter logic [2**N_IN-1:0]  TRUTH = 4'b1000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   output logic [N_IN-1:0]   VEC,
   output logic              VEC_VALID,
   input  logic              C_IN,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [N_IN:0]     ERR_COUNT,
   output logic [N_IN-1:0]   FIRST_FAIL,
   output logic              FAIL_SEEN
);

   localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
   localparam logic [N_IN-1:0] VEC_LAST  = '1;

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t            state_q;
   logic [HCW-1:0]    hold_q;
   logic [N_IN-1:0]   vec_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [N_IN:0]     err_q;
   logic [N_IN-1:0]   first_q;
   logic              seen_q;

   logic              sample_edge;
   logic              mismatch;
   logic [N_IN:0]     err_d;

   // C_IN is only trusted on the last hold cycle, once the block has settled.
   always_comb begin
      sample_edge = (state_q == DRIVE) && (hold_q == HOLD_LAST);
      mismatch    = sample_edge && (C_IN != TRUTH[vec_q]);
      err_d       = err_q + {{N_IN{1'b0}}, mismatch};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         hold_q  <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         first_q <= '0;
         seen_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START && !ABORT) begin
                  state_q <= DRIVE;
                  hold_q  <= '0;
                  vec_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  first_q <= '0;
                  seen_q  <= 1'b0;
               end
            end
            DRIVE: begin
               // Abort beats the final sample: partial results are kept, no DONE.
               if (ABORT) begin
                  state_q <= IDLE;
                  hold_q  <= '0;
                  vec_q   <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (sample_edge) begin
                  err_q  <= err_d;
                  hold_q <= '0;
                  if (mismatch && !seen_q) begin
                     first_q <= vec_q;
                     seen_q  <= 1'b1;
                  end
                  if (vec_q == VEC_LAST) begin
                     state_q <= IDLE;
                     vec_q   <= '0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end else begin
                     vec_q <= vec_q + N_IN'(1);
                  end
               end else begin
                  hold_q <= hold_q + HCW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign VEC        = vec_q;
   assign VEC_VALID  = valid_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign PASS       = pass_q;
   assign ERR_COUNT  = err_q;
   assign FIRST_FAIL = first_q;
   assign FAIL_SEEN  = seen_q;

endmodule

// File: tb/tb_comb_vector_sequencer.sv
// Directed bench for comb_vector_sequencer at defaults (N_IN=2, HOLD=4, AND truth table);
// a behavioural gate model drives C_IN from VEC.
module tb_comb_vector_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [1:0] VEC;
   logic       VEC_VALID;
   logic       C_IN;
   logic       BUSY;
   logic       DONE;
   logic       PASS;
   logic [2:0] ERR_COUNT;
   logic [1:0] FIRST_FAIL;
   logic       FAIL_SEEN;

   int checks = 0;
   int failures = 0;
   int mode = 0;   // 0: A&B  1: A|B  2: ~(A&B)  3: stuck at 0

   localparam logic [3:0] TRUTH_TB = 4'b1000;

   always #5 CLK = ~CLK;

   comb_vector_sequencer dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
      .VEC(VEC), .VEC_VALID(VEC_VALID), .C_IN(C_IN),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
      .FIRST_FAIL(FIRST_FAIL), .FAIL_SEEN(FAIL_SEEN)
   );

   function automatic logic gate(input int md, input logic [1:0] v);
      case (md)
         0: return v[1] & v[0];
         1: return v[1] | v[0];
         2: return ~(v[1] & v[0]);
         default: return 1'b0;
      endcase
   endfunction

   assign C_IN = gate(mode, VEC);

   function automatic bit is_bad(input int md, input int v);
      logic [3:0] t;
      t = TRUTH_TB;
      return gate(md, 2'(v)) != t[v];
   endfunction

   // Expected results after the first n vectors have been sampled.
   function automatic int exp_err(input int md, input int n);
      int e = 0;
      for (int v = 0; v < n; v++) if (is_bad(md, v)) e++;
      return e;
   endfunction

   function automatic int exp_first(input int md, input int n);
      for (int v = 0; v < n; v++) if (is_bad(md, v)) return v;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vec"}, 32'(VEC), 0);
      chk({tag, "_valid"}, 32'(VEC_VALID), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_pass"}, 32'(PASS), 0);
      chk({tag, "_err"}, 32'(ERR_COUNT), 0);
      chk({tag, "_first"}, 32'(FIRST_FAIL), 0);
      chk({tag, "_seen"}, 32'(FAIL_SEEN), 0);
   endtask

   // One run with gate model md; abort_at >= 0 raises ABORT during that run cycle.
   task automatic do_run(input string tag, input int md, input int abort_at);
      int n;
      int dones;
      mode = md;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk({tag, "_vec"}, 32'(VEC), 32'(i / 4));
         chk({tag, "_valid"}, 32'(VEC_VALID), 1);
         chk({tag, "_busy"}, 32'(BUSY), 1);
         chk({tag, "_err_run"}, 32'(ERR_COUNT), 32'(exp_err(md, i / 4)));
         if (i == abort_at) begin
            n = i / 4;
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            chk({tag, "_ab_busy"}, 32'(BUSY), 0);
            chk({tag, "_ab_valid"}, 32'(VEC_VALID), 0);
            chk({tag, "_ab_vec"}, 32'(VEC), 0);
            chk({tag, "_ab_pass"}, 32'(PASS), 0);
            chk({tag, "_ab_err"}, 32'(ERR_COUNT), 32'(exp_err(md, n)));
            chk({tag, "_ab_first"}, 32'(FIRST_FAIL), 32'(exp_first(md, n)));
            chk({tag, "_ab_seen"}, 32'(FAIL_SEEN), 32'(exp_err(md, n) != 0));
            dones = 0;
            for (int k = 0; k < 20; k++) begin
               if (DONE === 1'b1) dones++;
               tick();
            end
            chk({tag, "_ab_nodone"}, 32'(dones), 0);
            $display("run %s mode=%0d aborted err=%0d", tag, md, ERR_COUNT);
            return;
         end
         tick();
      end
      n = 4;
      chk({tag, "_done"}, 32'(DONE), 1);
      chk({tag, "_end_busy"}, 32'(BUSY), 0);
      chk({tag, "_end_valid"}, 32'(VEC_VALID), 0);
      chk({tag, "_end_vec"}, 32'(VEC), 0);
      chk({tag, "_pass"}, 32'(PASS), 32'(exp_err(md, n) == 0));
      chk({tag, "_err"}, 32'(ERR_COUNT), 32'(exp_err(md, n)));
      chk({tag, "_first"}, 32'(FIRST_FAIL), 32'(exp_first(md, n)));
      chk({tag, "_seen"}, 32'(FAIL_SEEN), 32'(exp_err(md, n) != 0));
      tick();
      chk({tag, "_done_pulse"}, 32'(DONE), 0);
      $display("run %s mode=%0d err=%0d first=%0d pass=%0d", tag, md, ERR_COUNT, FIRST_FAIL, PASS);
   endtask

   initial begin
      // Reset with START held high
      RST = 1'b1;
      START = 1'b1;
      tick();
      tick();
      chk_reset_vals("rst");
      RST = 1'b0;
      START = 1'b0;
      tick();
      chk("rst_idle_busy", 32'(BUSY), 0);
      $display("reset checked");

      do_run("and", 0, -1);
      do_run("or", 1, -1);
      do_run("nand", 2, -1);
      do_run("stuck0", 3, -1);

      // Abort in vector 2, then a clean run
      do_run("abort10", 1, 9);
      do_run("after_abort", 0, -1);
      // Abort on the final sample edge: last mismatch must not be counted
      do_run("abort_last", 3, 15);

      // START together with ABORT while idle
      START = 1'b1;
      ABORT = 1'b1;
      tick();
      START = 1'b0;
      ABORT = 1'b0;
      chk("start_abort_busy", 32'(BUSY), 0);
      chk("start_abort_valid", 32'(VEC_VALID), 0);
      $display("start+abort idle checked");

      // START while busy ignored, back-to-back run from DONE cycle, then RST mid-run
      mode = 1;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 16; i++) begin
         START = (i == 4);
         chk("b2b_vec", 32'(VEC), 32'(i / 4));
         tick();
      end
      START = 1'b0;
      chk("b2b_done", 32'(DONE), 1);
      chk("b2b_err1", 32'(ERR_COUNT), 2);
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("b2b_valid", 32'(VEC_VALID), 1);
      chk("b2b_busy", 32'(BUSY), 1);
      chk("b2b_vec0", 32'(VEC), 0);
      chk("b2b_err_clr", 32'(ERR_COUNT), 0);
      chk("b2b_seen_clr", 32'(FAIL_SEEN), 0);
      chk("b2b_done_off", 32'(DONE), 0);
      for (int i = 0; i < 7; i++) tick();
      chk("b2b_mid_vec", 32'(VEC), 1);
      chk("b2b_mid_err", 32'(ERR_COUNT), 0);
      RST = 1'b1;
      START = 1'b1;
      ABORT = 1'b1;
      tick();
      chk_reset_vals("midrst");
      RST = 1'b0;
      START = 1'b0;
      ABORT = 1'b0;
      $display("back-to-back and mid-run reset checked");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
